// File: rtl/uart_rx_fifo_pkg.sv
// +----------------------------------------------------------------------------+
// | uart_pkg                                                                   |
// | Shared defaults and the receive-entry type for the UART RX buffer.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package uart_pkg;

    localparam int C_DATA_W    = 16;
    localparam int C_TO_CYCLES = 1024;

    typedef struct packed {
        logic                err;
        logic [C_DATA_W-1:0] data;
    } rx_entry_t;

endpackage

`default_nettype wire

// File: rtl/uart_rx_fifo_if.sv
// +----------------------------------------------------------------------------+
// | uart_rx_fifo_if                                                            |
// | Receiver-side write port, software read port and status of the RX FIFO.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface uart_rx_fifo_if
    import uart_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DATA_W = C_DATA_W
);
    localparam int AW = $clog2(DEPTH);

    logic              clr;
    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              wr_err;
    logic              rd_req;
    logic [DATA_W-1:0] rd_data;
    logic              rd_err;
    logic              rd_valid;
    logic [AW:0]       level;
    logic              empty;
    logic              full;
    logic              ovf;
    logic              ovf_clr;
    logic [AW:0]       thresh;
    logic              irq;

    modport master (
        output clr, wr_valid, wr_data, wr_err, rd_req, ovf_clr, thresh,
        input  rd_data, rd_err, rd_valid, level, empty, full, ovf, irq
    );

    modport slave (
        input  clr, wr_valid, wr_data, wr_err, rd_req, ovf_clr, thresh,
        output rd_data, rd_err, rd_valid, level, empty, full, ovf, irq
    );

endinterface

`default_nettype wire

// File: rtl/uart_rx_fifo_mem.sv
// +----------------------------------------------------------------------------+
// | uart_fifo_mem                                                              |
// | FIFO storage: synchronous write port, registered read port.                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = C_DATA_W + 1,
    parameter int AW    = $clog2(DEPTH)
) (
    input  wire logic          pclk,
    input  wire logic          presetn,
    input  wire logic          wr_en,
    input  wire logic [AW-1:0] wr_addr,
    input  wire logic [W-1:0]  wr_din,
    input  wire logic          rd_en,
    input  wire logic [AW-1:0] rd_addr,
    output logic      [W-1:0]  rd_q
);

    logic [W-1:0] r_mem [DEPTH];
    logic [W-1:0] r_q;

    always_ff @(posedge pclk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_din;
        end
    end

    // A same-address write and read returns the old word, which is what a full-FIFO pop-and-push needs.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_q <= '0;
        end else if (rd_en) begin
            r_q <= r_mem[rd_addr];
        end
    end

    assign rd_q = r_q;

endmodule

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// +----------------------------------------------------------------------------+
// | uart_rx_fifo                                                               |
// | RX character FIFO with overflow flag, threshold and idle-timeout irq.      |
// | Optional macro UART_RX_ERR_TAG_EN stores the per-character error bit.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int DATA_W    = C_DATA_W,
    parameter int TO_CYCLES = C_TO_CYCLES
) (
    input  wire logic       pclk,
    input  wire logic       presetn,
    uart_rx_fifo_if.slave   bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TO_CYCLES + 1);
`ifdef UART_RX_ERR_TAG_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             r_empty;
    logic             r_full;
    logic             r_ovf;
    logic             r_rd_valid;
    logic             r_irq;
    logic [TW-1:0]    r_timer;

    logic             w_wr;
    logic             w_rd;
    logic             w_ovf_set;
    logic             w_timeout;
    logic [AW:0]      w_level_nxt;
    logic [MEM_W-1:0] w_wr_din;
    logic [MEM_W-1:0] w_rd_q;

    // A full FIFO still accepts a write when a pop frees the slot in the same cycle.
    assign w_wr      = bus.wr_valid && (!r_full || bus.rd_req) && !bus.clr;
    assign w_rd      = bus.rd_req && !r_empty && !bus.clr;
    assign w_ovf_set = bus.wr_valid && r_full && !bus.rd_req && !bus.clr;
    assign w_timeout = (r_timer == TW'(TO_CYCLES));

    always_comb begin
        w_level_nxt = r_level;
        if (bus.clr) begin
            w_level_nxt = '0;
        end else if (w_wr && !w_rd) begin
            w_level_nxt = r_level + 1'b1;
        end else if (w_rd && !w_wr) begin
            w_level_nxt = r_level - 1'b1;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_empty    <= 1'b1;
            r_full     <= 1'b0;
            r_ovf      <= 1'b0;
            r_rd_valid <= 1'b0;
            r_irq      <= 1'b0;
            r_timer    <= '0;
        end else begin
            r_level    <= w_level_nxt;
            r_empty    <= (w_level_nxt == '0);
            r_full     <= (w_level_nxt == (AW+1)'(DEPTH));
            r_rd_valid <= w_rd;

            if (bus.clr) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            end

            if (bus.clr) begin
                r_ovf <= 1'b0;
            end else if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (bus.ovf_clr) begin
                r_ovf <= 1'b0;
            end

            if (bus.clr || w_wr || w_rd || r_empty) begin
                r_timer <= '0;
            end else if (!w_timeout) begin
                r_timer <= r_timer + TW'(1);
            end

            // Registered from the settled state, so irq trails level by one cycle.
            r_irq <= ((bus.thresh != '0) && (r_level >= bus.thresh)) || w_timeout;
        end
    end

`ifdef UART_RX_ERR_TAG_EN
    assign w_wr_din    = {bus.wr_err, bus.wr_data};
    assign bus.rd_data = w_rd_q[DATA_W-1:0];
    assign bus.rd_err  = w_rd_q[DATA_W];
`else
    logic w_unused_err;
    assign w_unused_err = bus.wr_err;
    assign w_wr_din     = bus.wr_data;
    assign bus.rd_data  = w_rd_q;
    assign bus.rd_err   = 1'b0;
`endif

    uart_fifo_mem #(
        .DEPTH (DEPTH),
        .W     (MEM_W),
        .AW    (AW)
    ) u_mem (
        .pclk    (pclk),
        .presetn (presetn),
        .wr_en   (w_wr),
        .wr_addr (r_wr_ptr),
        .wr_din  (w_wr_din),
        .rd_en   (w_rd),
        .rd_addr (r_rd_ptr),
        .rd_q    (w_rd_q)
    );

    assign bus.rd_valid = r_rd_valid;
    assign bus.level    = r_level;
    assign bus.empty    = r_empty;
    assign bus.full     = r_full;
    assign bus.ovf      = r_ovf;
    assign bus.irq      = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
// +----------------------------------------------------------------------------+
// | tb_uart_rx_fifo                                                            |
// | Directed and random stimulus against a queue-based model of the RX FIFO.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int DEPTH = 8;
    localparam int DW    = 16;
    localparam int TO    = 16;
    localparam int AW    = 3;
`ifdef UART_RX_ERR_TAG_EN
    localparam bit TAG = 1'b1;
`else
    localparam bit TAG = 1'b0;
`endif

    logic pclk;
    logic presetn;

    uart_rx_fifo_if #(.DEPTH(DEPTH), .DATA_W(DW)) bus ();

    uart_rx_fifo #(
        .DEPTH     (DEPTH),
        .DATA_W    (DW),
        .TO_CYCLES (TO)
    ) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .bus     (bus.slave)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int n_vec = 0;
    int n_err = 0;

    rx_entry_t       q[$];
    logic [DW-1:0]   m_data;
    logic            m_err;
    logic            m_rv;
    logic            m_ovf;
    logic            m_irq;
    int              cyc;
    int              last_evt;
    int              thr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check_eq("rd_valid", 32'(bus.rd_valid), 32'(m_rv));
        check_eq("rd_data",  32'(bus.rd_data),  32'(m_data));
        check_eq("rd_err",   32'(bus.rd_err),   32'(m_err));
        check_eq("level",    32'(bus.level),    32'(q.size()));
        check_eq("empty",    32'(bus.empty),    32'(q.size() == 0));
        check_eq("full",     32'(bus.full),     32'(q.size() == DEPTH));
        check_eq("ovf",      32'(bus.ovf),      32'(m_ovf));
        check_eq("irq",      32'(bus.irq),      32'(m_irq));
    endtask

    task automatic model_reset();
        q.delete();
        m_data = '0; m_err = 1'b0; m_rv = 1'b0; m_ovf = 1'b0; m_irq = 1'b0;
        last_evt = cyc;
    endtask

    // One clock: apply inputs, advance the model on the edge, compare just after it.
    task automatic step(input bit wv, input logic [DW-1:0] wd, input bit we,
                        input bit rr, input bit c, input bit oc);
        int        sz;
        int        idle;
        bit        do_rd;
        bit        do_wr;
        rx_entry_t e;
        bus.wr_valid = wv; bus.wr_data = wd; bus.wr_err = we;
        bus.rd_req = rr; bus.clr = c; bus.ovf_clr = oc;
        bus.thresh = (AW+1)'(thr);
        @(posedge pclk);
        cyc++;
        sz   = q.size();
        idle = (sz != 0) ? ((cyc - 1 - last_evt) > TO ? TO : (cyc - 1 - last_evt)) : 0;
        m_irq = ((thr != 0) && (sz >= thr)) || (idle == TO);
        m_rv  = 1'b0;
        if (c) begin
            q.delete();
            m_ovf = 1'b0;
            last_evt = cyc;
        end else begin
            do_rd = rr && (sz != 0);
            do_wr = wv && ((sz < DEPTH) || rr);
            if (do_rd) begin
                e = q.pop_front();
                m_data = e.data;
                m_err  = TAG ? e.err : 1'b0;
                m_rv   = 1'b1;
            end
            if (do_wr) begin
                e.err = we; e.data = wd;
                q.push_back(e);
            end
            if (do_rd || do_wr) last_evt = cyc;
            if (wv && (sz == DEPTH) && !rr) m_ovf = 1'b1;
            else if (oc) m_ovf = 1'b0;
        end
        #1;
        check_outputs();
    endtask

    task automatic wr(input logic [DW-1:0] d, input bit e); step(1, d, e, 0, 0, 0); endtask
    task automatic rd();   step(0, '0, 0, 1, 0, 0); endtask
    task automatic idle(); step(0, '0, 0, 0, 0, 0); endtask

    task automatic async_reset();
        presetn = 1'b0;
        #3;
        model_reset();
        check_outputs();
        @(negedge pclk);
        @(negedge pclk);
        presetn = 1'b1;
    endtask

    initial begin
        cyc = 0; thr = 0;
        bus.wr_valid = 0; bus.wr_data = '0; bus.wr_err = 0; bus.rd_req = 0;
        bus.clr = 0; bus.ovf_clr = 0; bus.thresh = '0;
        presetn = 1'b1;
        #2;
        async_reset();
        check_eq("reset_empty", 32'(bus.empty), 32'd1);

        // Three characters, middle one flagged, drained in order.
        wr(16'h0041, 0); wr(16'h0042, 1); wr(16'h0043, 0);
        check_eq("level3", 32'(bus.level), 32'd3);
        rd(); check_eq("rd0", 32'(bus.rd_data), 32'h41);
        rd(); check_eq("rd1", 32'(bus.rd_data), 32'h42);
        check_eq("rd1_err", 32'(bus.rd_err), 32'(TAG));
        rd(); check_eq("rd2", 32'(bus.rd_data), 32'h43);
        check_eq("level0", 32'(bus.level), 32'd0);
        rd(); check_eq("underflow_rv", 32'(bus.rd_valid), 32'd0);

        // Overflow drops the ninth character.
        for (int i = 0; i < DEPTH; i++) wr(16'h0010 + 16'(i), 0);
        wr(16'h0055, 0);
        check_eq("ovf_set", 32'(bus.ovf), 32'd1);
        check_eq("ovf_level", 32'(bus.level), 32'd8);
        for (int i = 0; i < DEPTH; i++) begin
            rd(); check_eq("ovf_drain", 32'(bus.rd_data), 32'h10 + 32'(i));
        end
        step(0, '0, 0, 0, 0, 1);
        check_eq("ovf_clr", 32'(bus.ovf), 32'd0);

        // Full FIFO with simultaneous push and pop.
        for (int i = 0; i < DEPTH; i++) wr(16'h0020 + 16'(i), 0);
        step(1, 16'h0099, 0, 1, 0, 0);
        check_eq("full_rw_ovf", 32'(bus.ovf), 32'd0);
        check_eq("full_rw_lvl", 32'(bus.level), 32'd8);
        check_eq("full_rw_data", 32'(bus.rd_data), 32'h20);
        for (int i = 0; i < DEPTH; i++) rd();
        check_eq("last_99", 32'(bus.rd_data), 32'h99);

        // Threshold interrupt.
        thr = 4;
        for (int i = 0; i < 3; i++) wr(16'h0030 + 16'(i), 0);
        idle(); check_eq("thr_below", 32'(bus.irq), 32'd0);
        wr(16'h0033, 0); idle();
        check_eq("thr_hit", 32'(bus.irq), 32'd1);
        rd(); idle();
        check_eq("thr_drop", 32'(bus.irq), 32'd0);
        step(0, '0, 0, 0, 1, 0);

        // Idle timeout interrupt.
        thr = 0;
        wr(16'h0061, 0);
        for (int i = 1; i <= TO + 1; i++) begin
            idle();
            if (i == TO)     check_eq("to_early", 32'(bus.irq), 32'd0);
            if (i == TO + 1) check_eq("to_rise",  32'(bus.irq), 32'd1);
        end
        rd(); idle();
        check_eq("to_drop", 32'(bus.irq), 32'd0);
        wr(16'h0070, 0);
        step(1, 16'h0077, 0, 0, 1, 0);
        check_eq("clr_level", 32'(bus.level), 32'd0);

        // Reset in the middle of traffic.
        wr(16'h0081, 1); wr(16'h0082, 0);
        async_reset();

        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(99) < 3) thr = $urandom_range(DEPTH);
            if ($urandom_range(99) < 2) begin
                for (int k = 0; k < TO + 4; k++) idle();
            end else begin
                step($urandom_range(99) < 45, 16'($urandom), 1'($urandom),
                     $urandom_range(99) < 35, $urandom_range(99) < 2,
                     $urandom_range(99) < 5);
            end
        end

        bus.wr_valid = 0; bus.rd_req = 0; bus.clr = 0; bus.ovf_clr = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive buffer between the UART receiver and the APB register interface. It captures each character the receiver completes, including its parity/framing error bit, into a circular FIFO. Software drains the FIFO at its own pace, so back-to-back characters are not lost while the bus is busy. It raises a level interrupt on a programmable fill threshold, or when a partial FIFO has gone idle for a set time.

## Interface
Parameters:
- DEPTH, 8, number of entries; power of two, 2..256
- DATA_W, 16, character width; matches the receiver's data output
- TO_CYCLES, 1024, idle pclk cycles before the timeout interrupt; must be ≥1
- AW, $clog2(DEPTH), pointer width (derived, not overridden)

Ports:
- pclk  in  1  clock
- presetn  in  1  reset; asynchronous, active-low
- clr  in  1  synchronous flush pulse
- wr_valid  in  1  one-cycle pulse marking a completed received character
- wr_data  in  DATA_W  received character
- wr_err  in  1  parity/framing error for this character
- rd_req  in  1  pop request pulse from the APB read of the data register
- rd_data  out  DATA_W  popped character, registered
- rd_err  out  1  error bit of the popped character
- rd_valid  out  1  one-cycle pulse, rd_data/rd_err updated
- level  out  AW+1  current entry count, 0..DEPTH
- empty  out  1  level==0
- full  out  1  level==DEPTH
- ovf  out  1  sticky overflow flag
- ovf_clr  in  1  clears ovf
- thresh  in  AW+1  interrupt threshold; 0 disables the threshold interrupt
- irq  out  1  level interrupt, registered

## Operation
- Storage: DEPTH×(DATA_W+1) array; wr_ptr and rd_ptr each AW bits, wrapping modulo DEPTH; level counter AW+1 bits.
- Write: wr_valid && !full stores {wr_err,wr_data} at wr_ptr, then wr_ptr+1.
- Overflow: wr_valid && full && !rd_req drops the character and sets ovf. Stored data is untouched.
- Read: rd_req && !empty registers mem[rd_ptr] onto rd_data/rd_err, pulses rd_valid, then rd_ptr+1.
- Underflow: rd_req while empty does nothing. rd_valid stays 0 and rd_data holds its value. No flag is set.
- Simultaneous write and read: both are performed and level is unchanged. When full, the write is accepted because the read frees the slot in the same cycle, so ovf is not set.
- clr: resets both pointers and level to 0 and clears ovf. It takes priority over wr_valid/rd_req in the same cycle, so the character is discarded. rd_data is not changed.
- ovf: set has priority over ovf_clr in the same cycle.
- Idle timer: counts pclk cycles while !empty and no write occurs. It restarts on a write, a read, or clr, and holds at 0 while empty. It saturates at TO_CYCLES, which sets a timeout condition.
- irq = (thresh!=0 && level>=thresh) || timeout condition.
- irq stays high until the cause is removed: for threshold, level drops below thresh; for timeout, a read, write or clr restarts the timer.

## Timing
- Reset values: rd_data=0, rd_err=0, rd_valid=0, level=0, empty=1, full=0, ovf=0, irq=0. Internal pointers and the timer are also 0.
- Read latency: rd_valid and rd_data appear one cycle after the rd_req edge.
- Flags: level, empty and full reflect the write/read one cycle after the request.
- irq: one cycle behind level (registered from the post-update level). Timeout irq asserts TO_CYCLES+1 cycles after the last write.
- Reset mid-operation: on an asynchronous reset, everything returns to reset values immediately and memory contents are don't-care.
- Handshake: wr_valid and rd_req are single-cycle pulses. A held rd_req pops once per cycle.

## Configuration
- UART_RX_ERR_TAG_EN defined: the error bit is stored per entry and returned on rd_err.
- Not defined: memory is DATA_W wide, wr_err is ignored, and rd_err is tied to 0.

## Structure
- Package uart_pkg: DATA_W default, a typedef for the rx entry struct {err, data}, and the default TO_CYCLES.
- One sub-module, uart_fifo_mem, holds the storage array: a synchronous write port and a registered read port. Pointers, level, ovf, timer and irq logic stay in uart_rx_fifo.

## Test plan
- Reset with DEPTH=8 → empty=1, level=0, irq=0, ovf=0.
- Write 0x41, 0x42, 0x43 (err on 0x42), then 3 rd_req → rd_data 0x41/0x42/0x43, each one cycle after its request. rd_err=0,1,0; level 3→0.
- Fill 8 entries, write 0x55 → ovf=1, level=8. Reading 8 entries returns the original 8 with no 0x55. ovf_clr → ovf=0.
- Full FIFO, wr_valid and rd_req in the same cycle with 0x99 → ovf stays 0, level stays 8. 0x99 is read as the 8th entry after the popped one.
- thresh=4: 3 writes → irq=0; 4th write → irq=1 next cycle; one read → irq=0.
- thresh=0, TO_CYCLES=16, 1 write, then idle → irq rises at cycle 17. rd_req drops it. clr during a pending write discards that write → level=0.
